// File: rtl/button_step_generator.sv
// Debounced four-way button front end that drives a one-pixel step pulse
// with a slow auto-repeat phase that accelerates into a fast phase.
module button_step_generator #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_SLOW     = 5000000,
  parameter int REPEAT_FAST     = 1000000,
  parameter int ACCEL_COUNT     = 8
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic BTN_EAST,
  input  logic BTN_WEST,
  input  logic BTN_NORTH,
  input  logic BTN_SOUTH,
  output logic dir_east,
  output logic dir_west,
  output logic dir_north,
  output logic dir_south,
  output logic step_tick
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_SLOW > REPEAT_FAST) ?
                        REPEAT_SLOW : REPEAT_FAST;
  localparam int IW = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int RW = (ACCEL_COUNT > 1) ?
                      $clog2(ACCEL_COUNT) : 1;

  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] SLAST = IW'(REPEAT_SLOW - 1);
  localparam logic [IW-1:0] FLAST = IW'(REPEAT_FAST - 1);
  localparam logic [RW-1:0] ALAST = RW'(ACCEL_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } state_t;

  // bit order everywhere: 0 east, 1 west, 2 north, 3 south
  logic [3:0]    w_btn;
  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [3:0]    r_stable;
  logic [DW-1:0] r_dcnt [4];
  logic [3:0]    w_eff;
  logic [3:0]    r_dir;
  logic          w_active;
  logic          w_new;
  state_t        r_state;
  logic [IW-1:0] r_int;
  logic [RW-1:0] r_rep;
  logic          r_tick;

  assign w_btn = {BTN_SOUTH, BTN_NORTH, BTN_WEST, BTN_EAST};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_stable <= '0;
      r_dcnt   <= '{default: '0};
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DLAST) begin
          r_stable[i] <= ~r_stable[i];
          r_dcnt[i]   <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_eff[0] = r_stable[0] & ~r_stable[1];
  assign w_eff[1] = r_stable[1] & ~r_stable[0];
  assign w_eff[2] = r_stable[2] & ~r_stable[3];
  assign w_eff[3] = r_stable[3] & ~r_stable[2];

  assign w_active = |w_eff;
  // r_dir holds through a tick cycle, so a press landing there is
  // still seen as new one cycle later instead of being lost
  assign w_new = (|(w_eff & ~r_dir)) & ~r_tick;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_dir <= '0;
    end else if (!r_tick) begin
      r_dir <= w_eff;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_int   <= '0;
      r_rep   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_int <= '0;
          r_rep <= '0;
          if (w_active && !r_tick) begin
            r_tick  <= 1'b1;
            r_state <= SLOW;
          end
        end
        SLOW: begin
          if (!w_active) begin
            r_state <= IDLE;
            r_int   <= '0;
            r_rep   <= '0;
          end else if (w_new) begin
            r_tick <= 1'b1;
            r_int  <= '0;
            r_rep  <= '0;
          end else if (r_int == SLAST) begin
            if (!r_tick) begin
              r_tick <= 1'b1;
              r_int  <= '0;
              if (r_rep == ALAST) begin
                r_state <= FAST;
              end else begin
                r_rep <= r_rep + 1'b1;
              end
            end
          end else begin
            r_int <= r_int + 1'b1;
          end
        end
        FAST: begin
          if (!w_active) begin
            r_state <= IDLE;
            r_int   <= '0;
            r_rep   <= '0;
          end else if (w_new) begin
            r_tick  <= 1'b1;
            r_state <= SLOW;
            r_int   <= '0;
            r_rep   <= '0;
          end else if (r_int == FLAST) begin
            if (!r_tick) begin
              r_tick <= 1'b1;
              r_int  <= '0;
            end
          end else begin
            r_int <= r_int + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_int   <= '0;
          r_rep   <= '0;
        end
      endcase
    end
  end

  assign dir_east  = r_dir[0];
  assign dir_west  = r_dir[1];
  assign dir_north = r_dir[2];
  assign dir_south = r_dir[3];
  assign step_tick = r_tick;

endmodule

// File: tb/tb_button_step_generator.sv
// Directed bench for button_step_generator with short debounce and
// repeat intervals; expected latencies are hand-derived cycle counts.
module tb_button_step_generator;

  logic clk = 1'b0;
  logic rst;
  logic be, bw, bn, bs;
  logic de, dw, dn, ds;
  logic tick;

  int n_chk = 0;
  int n_err = 0;

  logic r_ptick = 1'b0;
  logic [3:0] r_pdir = '0;
  logic r_consec = 1'b0;
  logic r_dmove = 1'b0;

  always #5 clk = ~clk;

  button_step_generator #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_SLOW(10),
    .REPEAT_FAST(3),
    .ACCEL_COUNT(2)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .BTN_EAST(be),
    .BTN_WEST(bw),
    .BTN_NORTH(bn),
    .BTN_SOUTH(bs),
    .dir_east(de),
    .dir_west(dw),
    .dir_north(dn),
    .dir_south(ds),
    .step_tick(tick)
  );

  // flags back-to-back ticks and dir movement right after a tick
  always @(negedge clk) begin
    if (!rst) begin
      if (r_ptick && tick) r_consec <= 1'b1;
      if (r_ptick && ({ds, dn, dw, de} != r_pdir))
        r_dmove <= 1'b1;
    end
    r_ptick <= tick;
    r_pdir  <= {ds, dn, dw, de};
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_tick(input int lim, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < lim);
    if (!tick) n = 999;
  endtask

  task automatic count_ticks(input int k, output int t,
                             output logic [3:0] dor);
    t = 0;
    dor = '0;
    repeat (k) begin
      @(negedge clk);
      if (tick) t++;
      dor |= {ds, dn, dw, de};
    end
  endtask

  task automatic do_reset();
    be = 0; bw = 0; bn = 0; bs = 0;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
  endtask

  int n, t, k;
  logic [3:0] dor;

  initial begin
    be = 0; bw = 0; bn = 0; bs = 0;
    rst = 1'b1;
    cyc(2);
    chk("rst_dir", {28'd0, ds, dn, dw, de}, 0);
    chk("rst_tick", {31'd0, tick}, 0);
    rst = 1'b0;

    // east held: tick at 7, then 10, 10, 3, 3
    be = 1;
    wait_tick(8, n);
    chk("e_lat", n, 7);
    chk("e_dir", {31'd0, de}, 1);
    wait_tick(12, n);
    chk("e_gap1", n, 10);
    wait_tick(12, n);
    chk("e_gap2", n, 10);
    wait_tick(12, n);
    chk("e_fast1", n, 3);
    wait_tick(12, n);
    chk("e_fast2", n, 3);

    // south added in fast phase: prompt tick, then back to slow
    bs = 1;
    t = 0;
    for (int i = 0; i < 4; i++) begin
      wait_tick(12, n);
      t += n;
      if (ds || n == 999) break;
    end
    chk("s_lat_ok", {31'd0, (t >= 7 && t <= 9)}, 1);
    chk("s_dir", {30'd0, ds, de}, 3);
    wait_tick(12, n);
    chk("s_gap", n, 10);
    wait_tick(12, n);
    chk("s_gap2", n, 10);
    wait_tick(12, n);
    chk("s_fast", n, 3);

    // release everything while fast
    be = 0; bs = 0;
    cyc(12);
    chk("rel_dir", {28'd0, ds, dn, dw, de}, 0);
    chk("rel_idle", 32'(dut.r_state), 0);
    count_ticks(30, k, dor);
    chk("rel_ticks", k, 0);

    // short north glitch
    do_reset();
    bn = 1;
    cyc(3);
    bn = 0;
    count_ticks(20, k, dor);
    chk("gl_ticks", k, 0);
    chk("gl_north", {31'd0, dor[2]}, 0);

    // east and west conflict, then west released
    do_reset();
    be = 1; bw = 1;
    count_ticks(20, k, dor);
    chk("ew_ticks", k, 0);
    chk("ew_dirs", {28'd0, dor}, 0);
    bw = 0;
    wait_tick(12, n);
    chk("ew_lat", n, 7);
    chk("ew_dir", {30'd0, dw, de}, 1);

    // reset pulse while south repeating
    do_reset();
    bs = 1;
    wait_tick(12, n);
    chk("rs_first", n, 7);
    cyc(4);
    rst = 1'b1;
    @(negedge clk);
    chk("rs_dir", {28'd0, ds, dn, dw, de}, 0);
    chk("rs_tick", {31'd0, tick}, 0);
    rst = 1'b0;
    wait_tick(20, n);
    chk("rs_min", {31'd0, (n >= 7 && n != 999)}, 1);
    chk("rs_lat", n, 7);
    bs = 0;
    cyc(12);

    chk("no_consec", {31'd0, r_consec}, 0);
    chk("dir_hold", {31'd0, r_dmove}, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
